// File: rtl/timer_16_if.sv
// Control/status bundle for timer_16: load/value/enable/periodic in, count/tc/busy out.
interface timer_16_if #(
    parameter int BIT_SZ = 16
);
    logic              load;
    logic [BIT_SZ-1:0] value;
    logic              enable;
    logic              periodic;
    logic [BIT_SZ-1:0] count;
    logic              tc;
    logic              busy;

    modport master (
        output load, value, enable, periodic,
        input  count, tc, busy
    );

    modport slave (
        input  load, value, enable, periodic,
        output count, tc, busy
    );
endinterface

// File: rtl/timer_16.sv
// Loadable down-counter with one-shot or auto-reload mode and a registered terminal-count pulse.
module timer_16 #(
    parameter int BIT_SZ = 16
) (
    input  logic       clock,
    input  logic       reset,
    timer_16_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [BIT_SZ-1:0] ZERO = '0;
    localparam logic [BIT_SZ-1:0] ONE  = BIT_SZ'(1);

    state_t            state_reg, state_next;
    logic [BIT_SZ-1:0] count_reg, count_next;
    logic              tc_reg, tc_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= ZERO;
            tc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tc_reg    <= tc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tc_next    = 1'b0;
        if (bus.load) begin
            count_next = bus.value;
            state_next = (bus.value != ZERO) ? RUN : IDLE;
        end else if (state_reg == RUN && bus.enable) begin
            if (count_reg > ONE) begin
                count_next = count_reg - ONE;
            end else begin
                // Terminal edge; count==0 in RUN cannot occur but is also retired here.
                tc_next = 1'b1;
                if (bus.periodic && bus.value != ZERO) begin
                    count_next = bus.value;
                end else begin
                    count_next = ZERO;
                    state_next = IDLE;
                end
            end
        end
    end

    assign bus.count = count_reg;
    assign bus.tc    = tc_reg;
    assign bus.busy  = (state_reg == RUN);
endmodule

// File: tb/tb_timer_16.sv
// Directed scoreboard bench for timer_16: expectations queued at drive time, checked after each edge.
module tb_timer_16;
    typedef struct packed {
        logic [15:0] cnt;
        logic        tc;
        logic        busy;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   quiet = 1'b0;
    exp_t sb_q[$];
    string tag_q[$];

    always #5 clock = ~clock;

    timer_16_if #(.BIT_SZ(16)) bus ();
    timer_16 #(.BIT_SZ(16)) dut (.clock(clock), .reset(reset), .bus(bus));

    task automatic expect_push(input logic [15:0] ec, input logic etc, input logic eb, input string tag);
        exp_t e;
        e.cnt = ec; e.tc = etc; e.busy = eb;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert ({bus.count, bus.tc, bus.busy} === {e.cnt, e.tc, e.busy}) else begin
            n_err++;
            $error("FAIL %s: got count=%0d tc=%0b busy=%0b, expected count=%0d tc=%0b busy=%0b",
                   t, bus.count, bus.tc, bus.busy, e.cnt, e.tc, e.busy);
        end
        if (!quiet)
            $display("[%0t] %s: count=%0d tc=%0b busy=%0b", $time, t, bus.count, bus.tc, bus.busy);
    endtask

    // One clock: drive on the falling edge, queue the expectation, check 1ns after the rising edge.
    task automatic cyc(input logic ld, input logic [15:0] v, input logic en, input logic per,
                       input logic [15:0] ec, input logic etc, input logic eb, input string tag);
        @(negedge clock);
        bus.load = ld; bus.value = v; bus.enable = en; bus.periodic = per;
        expect_push(ec, etc, eb, tag);
        @(posedge clock);
        #1;
        check_pop();
    endtask

    initial begin
        reset = 1'b0;
        bus.load = 1'b0; bus.value = '0; bus.enable = 1'b0; bus.periodic = 1'b0;
        #3;
        expect_push(16'd0, 1'b0, 1'b0, "reset_state");
        check_pop();
        @(negedge clock);
        reset = 1'b1;

        // IDLE ignores enable and periodic
        for (int i = 0; i < 3; i++) cyc(0, 16'd9, 1, 1, 16'd0, 0, 0, "idle_hold");

        // One-shot from 5; a value change mid-run must not matter
        cyc(1, 16'd5, 0, 0, 16'd5, 0, 1, "os_load");
        cyc(0, 16'd123, 1, 0, 16'd4, 0, 1, "os_dec");
        cyc(0, 16'd5, 1, 0, 16'd3, 0, 1, "os_dec");
        cyc(0, 16'd5, 1, 0, 16'd2, 0, 1, "os_dec");
        cyc(0, 16'd5, 1, 0, 16'd1, 0, 1, "os_dec");
        cyc(0, 16'd5, 1, 0, 16'd0, 1, 0, "os_tc");
        cyc(0, 16'd5, 1, 1, 16'd0, 0, 0, "os_after");
        cyc(0, 16'd5, 1, 1, 16'd0, 0, 0, "os_after");

        // Periodic 3: 3,2,1,3,2,1...
        cyc(1, 16'd3, 1, 1, 16'd3, 0, 1, "per_load");
        for (int k = 0; k < 3; k++) begin
            cyc(0, 16'd3, 1, 1, 16'd2, 0, 1, "per_2");
            cyc(0, 16'd3, 1, 1, 16'd1, 0, 1, "per_1");
            cyc(0, 16'd3, 1, 1, 16'd3, 1, 1, "per_reload");
        end

        // Gating at count 4
        cyc(1, 16'd6, 1, 1, 16'd6, 0, 1, "gate_load");
        cyc(0, 16'd6, 1, 1, 16'd5, 0, 1, "gate_dec");
        cyc(0, 16'd6, 1, 1, 16'd4, 0, 1, "gate_dec");
        for (int i = 0; i < 10; i++) cyc(0, 16'd6, 0, 1, 16'd4, 0, 1, "gate_hold");
        cyc(0, 16'd6, 1, 1, 16'd3, 0, 1, "gate_resume");

        // Load collides with terminal edge
        cyc(0, 16'd6, 1, 1, 16'd2, 0, 1, "col_dec");
        cyc(0, 16'd6, 1, 1, 16'd1, 0, 1, "col_dec");
        cyc(1, 16'd7, 1, 1, 16'd7, 0, 1, "col_load7");
        for (int i = 6; i >= 1; i--) cyc(0, 16'd7, 1, 0, 16'(i), 0, 1, "col_run");
        cyc(1, 16'd0, 1, 0, 16'd0, 0, 0, "col_load0");

        // Reload takes value sampled at the reload edge; periodic sampled at count==1
        cyc(1, 16'd2, 1, 1, 16'd2, 0, 1, "rl_load");
        cyc(0, 16'd2, 1, 1, 16'd1, 0, 1, "rl_dec");
        cyc(0, 16'd4, 1, 1, 16'd4, 1, 1, "rl_newval");
        cyc(0, 16'd4, 1, 0, 16'd3, 0, 1, "rl_dec");
        cyc(0, 16'd4, 1, 0, 16'd2, 0, 1, "rl_dec");
        cyc(0, 16'd4, 1, 1, 16'd1, 0, 1, "rl_dec");
        cyc(0, 16'd4, 1, 0, 16'd0, 1, 0, "rl_oneshot_end");

        // Periodic reload with value 0 retires to IDLE
        cyc(1, 16'd2, 1, 1, 16'd2, 0, 1, "rl0_load");
        cyc(0, 16'd2, 1, 1, 16'd1, 0, 1, "rl0_dec");
        cyc(0, 16'd0, 1, 1, 16'd0, 1, 0, "rl0_tc");
        cyc(0, 16'd0, 1, 1, 16'd0, 0, 0, "rl0_idle");

        // Value 1 periodic: tc every cycle
        cyc(1, 16'd1, 1, 1, 16'd1, 0, 1, "v1_load");
        for (int i = 0; i < 4; i++) cyc(0, 16'd1, 1, 1, 16'd1, 1, 1, "v1_tc");

        // Async reset between edges at count 9
        cyc(1, 16'd12, 1, 1, 16'd12, 0, 1, "ar_load");
        cyc(0, 16'd12, 1, 1, 16'd11, 0, 1, "ar_dec");
        cyc(0, 16'd12, 1, 1, 16'd10, 0, 1, "ar_dec");
        cyc(0, 16'd12, 1, 1, 16'd9, 0, 1, "ar_dec");
        #2;
        reset = 1'b0;
        #1;
        expect_push(16'd0, 1'b0, 1'b0, "ar_immediate");
        check_pop();
        cyc(0, 16'd12, 1, 1, 16'd0, 0, 0, "ar_held");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 16'd12, 1, 1, 16'd0, 0, 0, "ar_released");

        // Full-range one-shot
        cyc(1, 16'hFFFF, 0, 0, 16'hFFFF, 0, 1, "max_load");
        quiet = 1'b1;
        for (int i = 16'hFFFE; i >= 1; i--) cyc(0, 16'hFFFF, 1, 0, 16'(i), 0, 1, "max_run");
        quiet = 1'b0;
        cyc(0, 16'hFFFF, 1, 0, 16'd0, 1, 0, "max_tc");
        cyc(0, 16'hFFFF, 1, 0, 16'd0, 0, 0, "max_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_16.md
TIMER_16 -- requirements
Module: timer_16

Interface
REQ-001 SHALL have parameter BIT_SZ, default 16, giving the width of value and count.
REQ-002 SHALL have port: clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: load  input  1  high loads value into count and arms the timer.
REQ-005 SHALL have port: value  input  BIT_SZ  load/reload value (period in enabled cycles).
REQ-006 SHALL have port: enable  input  1  high permits counting down while running.
REQ-007 SHALL have port: periodic  input  1  1 = auto-reload at terminal count, 0 = one-shot.
REQ-008 SHALL have port: count  output  BIT_SZ  current registered count.
REQ-009 SHALL have port: tc  output  1  registered one-cycle terminal-count pulse.
REQ-010 SHALL have port: busy  output  1  high while in state RUN.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and RUN; busy = (state == RUN), with no other logic on busy.
REQ-012 Priority on each rising edge SHALL be load > counting > hold.
REQ-013 On load=1 in any state: count <= value; tc <= 0; next state RUN if value != 0, else IDLE.
REQ-014 In IDLE with load=0: count and state hold; tc <= 0; enable and periodic are ignored.
REQ-015 In RUN with load=0 and enable=0: count and state hold; tc <= 0.
REQ-016 In RUN with load=0, enable=1 and count > 1: count <= count - 1; tc <= 0; stay in RUN.
REQ-017 In RUN with load=0, enable=1, count == 1 and periodic=0: count <= 0; tc <= 1; next state IDLE.
REQ-018 In RUN with load=0, enable=1, count == 1 and periodic=1: count <= value; tc <= 1; stay in RUN if value != 0, else count <= 0 and next state IDLE.
REQ-019 value SHALL be sampled only on a load edge or a reload edge; changes at other times SHALL have no effect.
REQ-020 periodic SHALL be sampled only on the count == 1 decision edge.
REQ-021 tc SHALL be high for exactly one clock per terminal event and never on consecutive cycles unless value == 1 in periodic mode.
REQ-022 With periodic=1 and enable held high, tc SHALL pulse every value clocks, first pulse value clocks after the load edge.
REQ-023 Arithmetic SHALL be unsigned BIT_SZ bits; count SHALL never decrement below 0 or wrap to all-ones.
REQ-024 load coincident with a terminal edge (count == 1, enable=1) SHALL take the load, with tc = 0 on that edge.
REQ-025 value = all-ones SHALL count the full 2^BIT_SZ - 1 enabled cycles without overflow.

Reset
REQ-026 reset low SHALL immediately force count = 0, tc = 0, state = IDLE (busy = 0), regardless of clock.
REQ-027 Deassertion of reset SHALL take effect at the next rising clock edge; until a load arrives the block stays in IDLE with count = 0.
REQ-028 reset asserted mid-run SHALL abandon the count with no tc pulse.

Verification
REQ-029 One-shot: load value=5 with periodic=0, then enable=1 -> count 5,4,3,2,1,0; tc high for one cycle as count reaches 0; busy falls on that same edge; count stays 0.
REQ-030 Periodic: load value=3 with periodic=1, enable=1 continuously -> count 3,2,1,3,2,1,...; tc pulses every 3 clocks; busy stays 1.
REQ-031 Gating: in RUN at count=4, enable=0 for 10 cycles -> count holds at 4 and tc stays 0; resumes at 3 on re-enable.
REQ-032 Collisions: load value=7 on the edge where count=1 and enable=1 -> count=7, tc=0, busy=1; load value=0 -> count=0, busy=0, tc=0.
REQ-033 Async reset: reset low between clock edges at count=9 in RUN -> count=0, busy=0, tc=0 without waiting for a clock edge; no tc after release.
REQ-034 Extremes: BIT_SZ=16, value=16'hFFFF, one-shot -> exactly 65535 enabled clocks to tc; value=1 periodic -> tc high every cycle, count stays 1.
